// File: rtl/mul_share_sched.sv
// mul_share_sched: round-robin scheduler sharing one exact 16x16 unsigned
// multiplier between NUM_REQ (2..4) requesters. The granted requester's
// operands drive the combinational multiplier; the product and requester ID
// are captured into a single-entry result buffer with a valid/ready handshake.
// Optional build macro MUL_SHARE_SCHED_CNT_EN adds a 16-bit accept counter
// output op_count.

// Exact combinational 16x16 unsigned multiplier (shift-and-add array).
module exact_16x16_mul (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  logic [31:0] pp [16];

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_pp
      assign pp[gi] = b[gi] ? ({16'd0, a} << gi) : 32'd0;
    end
  endgenerate

  // Sum all partial products into the full 32-bit product
  always_comb begin
    p = 32'd0;
    for (int i = 0; i < 16; i++) begin
      p = p + pp[i];
    end
  end

endmodule

module mul_share_sched #(
  parameter int NUM_REQ = 4,   // legal range 2..4
  parameter int WIDTH   = 16   // must stay 16 to match the multiplier
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [2*WIDTH-1:0]       res_p,
  output logic [1:0]               res_id
`ifdef MUL_SHARE_SCHED_CNT_EN
  ,
  output logic [15:0]              op_count
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  // Registered state
  state_t       state_q,     state_d;
  logic         res_valid_q, res_valid_d;
  logic [31:0]  res_p_q,     res_p_d;
  logic [1:0]   res_id_q,    res_id_d;
  logic [1:0]   rr_ptr_q,    rr_ptr_d;

  // Operands padded to four slots so a 2-bit grant index always fits
  logic [15:0]  op_a_pad [4];
  logic [15:0]  op_b_pad [4];
  logic [3:0]   valid_pad;

  logic         gnt_found;
  logic [1:0]   gnt_idx;
  logic         can_accept;
  logic         accept;
  logic [15:0]  mul_a;
  logic [15:0]  mul_b;
  logic [31:0]  mul_p;

  assign valid_pad = 4'(req_valid);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_unpack
      if (gi < NUM_REQ) begin : g_live
        assign op_a_pad[gi] = req_a[WIDTH*gi +: WIDTH];
        assign op_b_pad[gi] = req_b[WIDTH*gi +: WIDTH];
      end else begin : g_absent
        assign op_a_pad[gi] = 16'd0;
        assign op_b_pad[gi] = 16'd0;
      end
    end
  endgenerate

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    logic [2:0] cand;
    gnt_found = 1'b0;
    gnt_idx   = 2'd0;
    cand      = 3'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + 3'(k);
      if (cand >= 3'(NUM_REQ)) begin
        cand = cand - 3'(NUM_REQ);
      end
      if (!gnt_found && valid_pad[cand[1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[1:0];
      end
    end
  end

  // Buffer can take a new product if empty or being drained this cycle
  assign can_accept = !res_valid_q || res_ready;
  assign accept     = !rst && can_accept && gnt_found;

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = accept && (gnt_idx == 2'(gi));
    end
  endgenerate

  assign mul_a = op_a_pad[gnt_idx];
  assign mul_b = op_b_pad[gnt_idx];

  exact_16x16_mul u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  // Next-state logic for the result buffer FSM and round-robin pointer
  always_comb begin
    state_d     = state_q;
    res_p_d     = res_p_q;
    res_id_d    = res_id_q;
    rr_ptr_d    = rr_ptr_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (res_ready && !accept) begin
          // Drained with nothing to refill; payload keeps last values
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // An accept always loads the buffer, including consume-and-refill
    if (accept) begin
      res_p_d  = mul_p;
      res_id_d = gnt_idx;
      rr_ptr_d = (gnt_idx == 2'(NUM_REQ - 1)) ? 2'd0 : gnt_idx + 2'd1;
    end

    res_valid_d = (state_d == FULL);
  end

  // State register with synchronous reset; pending result is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      res_valid_q <= 1'b0;
      res_p_q     <= 32'd0;
      res_id_q    <= 2'd0;
      rr_ptr_q    <= 2'd0;
    end else begin
      state_q     <= state_d;
      res_valid_q <= res_valid_d;
      res_p_q     <= res_p_d;
      res_id_q    <= res_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_p     = res_p_q;
  assign res_id    = res_id_q;

`ifdef MUL_SHARE_SCHED_CNT_EN
  logic [15:0] op_count_q, op_count_d;

  // Count accepted operations; wraps naturally at 16 bits
  always_comb begin
    op_count_d = op_count_q;
    if (accept) begin
      op_count_d = op_count_q + 16'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q <= 16'd0;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_mul_share_sched.sv
// Directed testbench for mul_share_sched with hand-computed products.
module tb_mul_share_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_p;
  logic [1:0]  res_id;
`ifdef MUL_SHARE_SCHED_CNT_EN
  logic [15:0] op_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  mul_share_sched #(.NUM_REQ(4), .WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_p     (res_p),
    .res_id    (res_id)
`ifdef MUL_SHARE_SCHED_CNT_EN
    ,
    .op_count  (op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int idx, input logic [15:0] a, input logic [15:0] b);
    req_a[16*idx +: 16] = a;
    req_b[16*idx +: 16] = b;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Watchdog so the run always terminates
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  exp_ids [4];
    logic [31:0] exp_ps  [4];
    exp_ids = '{2'd0, 2'd1, 2'd2, 2'd3};
    exp_ps  = '{32'd5479448, 32'd4577430, 32'd1078980, 32'hFFFE0001};

    rst       = 1'b1;
    req_valid = 4'b0000;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
    tick();
    // req_ready must stay low while reset is asserted, even with a valid request
    req_valid = 4'b0001;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    tick();
    req_valid = 4'b0000;
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_p", res_p, 32'd0);
    check("rst_res_id", 32'(res_id), 32'd0);
    check("rst_rr_ptr", 32'(dut.rr_ptr_q), 32'd0);
    rst = 1'b0;

    // Single request from requester 0
    set_op(0, 16'd420, 16'd2569);
    req_valid = 4'b0001;
    #1;
    check("single_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0000;
    check("single_valid", 32'(res_valid), 32'd1);
    check("single_p", res_p, 32'd1078980);
    check("single_id", 32'(res_id), 32'd0);
    tick();
    check("single_drain", 32'(res_valid), 32'd0);
    check("single_hold_p", res_p, 32'd1078980);

    // All four valid: grants 0,1,2,3 back to back
    do_reset();
    set_op(0, 16'd4888, 16'd1121);
    set_op(1, 16'd2145, 16'd2134);
    set_op(2, 16'd420, 16'd2569);
    set_op(3, 16'd65535, 16'd65535);
    req_valid = 4'b1111;
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr_ready%0d", k), 32'(req_ready), 32'(4'b0001 << k));
      tick();
      check($sformatf("rr_valid%0d", k), 32'(res_valid), 32'd1);
      check($sformatf("rr_p%0d", k), res_p, exp_ps[k]);
      check($sformatf("rr_id%0d", k), 32'(res_id), 32'(exp_ids[k]));
    end
    req_valid = 4'b0000;
    tick();

    // Backpressure: hold a result while requester 1 waits
    res_ready = 1'b0;
    set_op(0, 16'd420, 16'd2569);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp_ready%0d", k), 32'(req_ready), 32'd0);
      check($sformatf("bp_p%0d", k), res_p, 32'd1078980);
      check($sformatf("bp_id%0d", k), 32'(res_id), 32'd0);
      tick();
    end
    res_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b0000;
    check("bp_refill_valid", 32'(res_valid), 32'd1);
    check("bp_refill_p", res_p, 32'd4577430);
    check("bp_refill_id", 32'(res_id), 32'd1);
    tick();

    // Fairness between requesters 0 and 2
    do_reset();
    set_op(0, 16'd4888, 16'd1121);
    set_op(2, 16'd420, 16'd2569);
    req_valid = 4'b0101;
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("fair_ready%0d", k), 32'(req_ready), (k % 2 == 0) ? 32'b0001 : 32'b0100);
      tick();
      check($sformatf("fair_id%0d", k), 32'(res_id), (k % 2 == 0) ? 32'd0 : 32'd2);
      check($sformatf("fair_p%0d", k), res_p, (k % 2 == 0) ? 32'd5479448 : 32'd1078980);
      if (k == 1) begin
        check("fair_rr_after2", 32'(dut.rr_ptr_q), 32'd3);
      end
    end
    req_valid = 4'b0000;
    tick();

    // Reset while holding a stalled result
    res_ready = 1'b0;
    req_valid = 4'b0001;
    tick();
    check("midrst_full", 32'(res_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_ready", 32'(req_ready), 32'd0);
    tick();
    check("midrst_valid", 32'(res_valid), 32'd0);
    check("midrst_p", res_p, 32'd0);
    check("midrst_rr", 32'(dut.rr_ptr_q), 32'd0);
    rst       = 1'b0;
    req_valid = 4'b0100;
    res_ready = 1'b1;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b0000;
    check("post_rst_p", res_p, 32'd1078980);
    check("post_rst_id", 32'(res_id), 32'd2);
    tick();

`ifdef MUL_SHARE_SCHED_CNT_EN
    do_reset();
    check("cnt_reset", 32'(op_count), 32'd0);
    res_ready = 1'b1;
    req_valid = 4'b0001;
    for (int k = 0; k < 3; k++) tick();
    req_valid = 4'b0000;
    tick();
    check("cnt_three", 32'(op_count), 32'd3);
    // Stall does not affect the count
    res_ready = 1'b0;
    tick();
    tick();
    check("cnt_stall", 32'(op_count), 32'd3);
    res_ready = 1'b1;
    req_valid = 4'b0001;
    for (int k = 0; k < 65533; k++) tick();
    req_valid = 4'b0000;
    tick();
    check("cnt_wrap", 32'(op_count), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("cnt_rst_again", 32'(op_count), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_share_sched.md
Name: mul_share_sched

Overview:
- Round-robin scheduler that shares one exact_16x16_mul instance between up to four requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The winner's operands drive the combinational multiplier; the product is registered with the requester ID into a single-entry result buffer with its own valid/ready handshake.
- Sits between multiple datapath clients and the multiplier, replacing per-client multipliers.

Parameters:
- NUM_REQ, 4, number of requesters, legal range 2..4.
- WIDTH, 16, operand width; fixed to match exact_16x16_mul, other values illegal.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*16  flattened operand A; requester i uses bits [16i+15:16i].
- req_b  input  NUM_REQ*16  flattened operand B, same packing.
- res_valid  output  1  result buffer holds a product.
- res_ready  input  1  downstream consumes result.
- res_p  output  32  unsigned product a*b.
- res_id  output  2  index of requester that issued res_p.

Behaviour:
- Reset (rst=1 at posedge): res_valid=0, res_p=0, res_id=0, rr_ptr=0, state=IDLE.
  - req_ready forced 0 combinationally while rst=1.
  - A result pending at reset is discarded, not delivered.
- Arbitration (combinational):
  - Search req_valid starting at rr_ptr, ascending, wrapping modulo NUM_REQ; first set bit is grant g.
  - No valid requester: no grant.
- can_accept = !res_valid || res_ready.
- req_ready[i] = !rst && can_accept && (any req_valid) && (i==g).
  - req_ready may depend on req_valid and res_ready; requesters must not make req_valid depend on req_ready.
- Accept event = req_valid[g] && req_ready[g] at posedge:
  - res_p <= a_g*b_g (unsigned, full 32 bits, no truncation).
  - res_id <= g.
  - res_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_REQ.
- rr_ptr changes only on accept.
- Latency: product visible exactly one cycle after the accept edge.
- Throughput: one product per cycle when res_ready is held high.
- FSM:
  - IDLE (res_valid=0): accept -> FULL; else stay.
  - FULL (res_valid=1):
    - res_ready=1 with accept -> FULL, buffer overwritten with new result (simultaneous consume and refill).
    - res_ready=1, no accept -> IDLE, res_valid=0; res_p/res_id keep last values.
    - res_ready=0 -> stay, all req_ready=0, res_p/res_id stable.
- Requesters that are not granted hold their operands and valid; no starvation, worst-case wait NUM_REQ-1 accepts.
- Requester indices >= NUM_REQ do not exist; res_id upper values are unused when NUM_REQ<4.

Optional Feature:
- Macro MUL_SHARE_SCHED_CNT_EN.
- Defined:
  - Adds output port op_count (16 bits), reset to 0.
  - Increments by 1 on every accept event.
  - Wraps 16'hFFFF -> 0.
  - Unaffected by res_ready stalls.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then req_valid=0001 with a=420, b=2569 -> req_ready=0001 same cycle; next cycle res_valid=1, res_p=1078980, res_id=0.
- All four valid with (4888,1121), (2145,2134), (420,2569), (65535,65535), res_ready=1 -> grants in order 0,1,2,3 on consecutive cycles.
  - res_p sequence: 5479448, 4577430, 1078980, 32'hFFFE0001.
  - res_id sequence: 0,1,2,3.
- Backpressure: FULL with res_ready=0 for 5 cycles while requester 1 is valid -> req_ready=0, res_p/res_id stable.
  - Raise res_ready -> old result consumed and requester 1 accepted on the same edge, no bubble.
- Fairness: requesters 0 and 2 continuously valid, res_ready=1 -> grants alternate 0,2,0,2; rr_ptr after the grant to 2 equals 3, and the next grant is 0.
- Reset mid-operation: assert rst while FULL with res_ready=0 -> next cycle res_valid=0, res_p=0, rr_ptr=0, req_ready=0 during rst.
  - First request after release is served normally.
- MUL_SHARE_SCHED_CNT_EN defined: 3 accepts -> op_count=3.
  - Preload path: 65536 accepts -> op_count wraps to 0.
  - Reset -> op_count=0.
